// File: rtl/inst_fetch_operand_unit_if.sv
// Bus bundle for the fetch/operand unit: memory read port, register-file read
// port and the {op,a,b} valid/ready output toward the ALU stage.
interface inst_fetch_operand_unit_if #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int RW = 4
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [RW-1:0] reg_idx;
  logic [DW-1:0] reg_rdata;
  logic [3:0]    op;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output mem_req, mem_addr, input mem_rdata, mem_ack,
    output reg_idx, input reg_rdata,
    output op, a, b, out_valid, input out_ready
  );

  modport slave (
    input mem_req, mem_addr, output mem_rdata, mem_ack,
    input reg_idx, output reg_rdata,
    input op, a, b, out_valid, output out_ready
  );
endinterface

// File: rtl/inst_fetch_operand_unit.sv
// Instruction fetch + operand resolution: fetches 3-word instructions, resolves
// operands A and B through four addressing modes, hands {op,a,b} to the ALU.
module inst_fetch_operand_unit #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          run,
  output logic          busy,
  output logic [AW-1:0] pc,
  inst_fetch_operand_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_OA, S_OA_M, S_OB, S_OB_M, S_OUT
  } state_t;

  typedef enum logic [1:0] {
    M_REG = 2'b00, M_MEM = 2'b01, M_IDX = 2'b10, M_IMM = 2'b11
  } mode_t;

  state_t        state_q, state_d;
  logic [7:0]    hdr_q;   // w0 header: {op, mode_a, mode_b}; reserved bits are never stored
  logic [DW-1:0] w1_q, w2_q, a_q, b_q;
  logic [AW-1:0] pc_q, ea_q;

  logic          on_b;
  logic [DW-1:0] spec;
  mode_t         mode;
  logic          mem_operand;
  logic [DW-1:0] opnd;
  logic [AW-1:0] ea_next;

  // Operand phase B reuses the A-phase datapath with w2 and mode_b selected.
  always_comb begin
    on_b        = (state_q == S_OB) || (state_q == S_OB_M);
    spec        = on_b ? w2_q : w1_q;
    mode        = mode_t'(on_b ? hdr_q[1:0] : hdr_q[3:2]);
    mem_operand = (mode == M_MEM) || (mode == M_IDX);
    opnd        = (mode == M_REG) ? bus.reg_rdata : spec;
    ea_next     = (mode == M_IDX) ? spec[AW-1:0] + bus.reg_rdata[AW-1:0]
                                  : spec[AW-1:0];
  end

  // NOTE: every output gets a default first so no path through the case leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    bus.reg_idx  = '0;
    unique case (state_q)
      S_F0:   begin bus.mem_req = 1'b1; bus.mem_addr = pc_q;            end
      S_F1:   begin bus.mem_req = 1'b1; bus.mem_addr = pc_q + AW'(1);   end
      S_F2:   begin bus.mem_req = 1'b1; bus.mem_addr = pc_q + AW'(2);   end
      S_OA_M,
      S_OB_M: begin bus.mem_req = 1'b1; bus.mem_addr = ea_q;            end
      S_OA,
      S_OB:   bus.reg_idx = (mode == M_IDX) ? spec[AW+RW-1:AW] : spec[RW-1:0];
      default: ;
    endcase
  end

  assign bus.op        = hdr_q[7:4];
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.out_valid = (state_q == S_OUT);
  assign busy          = (state_q != S_IDLE);
  assign pc            = pc_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start)       state_d = S_F0;
      S_F0:   if (bus.mem_ack) state_d = S_F1;
      S_F1:   if (bus.mem_ack) state_d = S_F2;
      S_F2:   if (bus.mem_ack) state_d = S_OA;
      S_OA:   state_d = mem_operand ? S_OA_M : S_OB;
      S_OA_M: if (bus.mem_ack) state_d = S_OB;
      S_OB:   state_d = mem_operand ? S_OB_M : S_OUT;
      S_OB_M: if (bus.mem_ack) state_d = S_OUT;
      S_OUT:  if (bus.out_ready) state_d = run ? S_F0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q  <= '0;
      ea_q  <= '0;
      hdr_q <= '0;
      w1_q  <= '0;
      w2_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start)       pc_q  <= start_addr;
        S_F0:   if (bus.mem_ack) hdr_q <= bus.mem_rdata[DW-1:DW-8];
        S_F1:   if (bus.mem_ack) w1_q  <= bus.mem_rdata;
        S_F2:   if (bus.mem_ack) w2_q  <= bus.mem_rdata;
        S_OA:   if (mem_operand) ea_q <= ea_next; else a_q <= opnd;
        S_OA_M: if (bus.mem_ack) a_q   <= bus.mem_rdata;
        S_OB:   if (mem_operand) ea_q <= ea_next; else b_q <= opnd;
        S_OB_M: if (bus.mem_ack) b_q   <= bus.mem_rdata;
        S_OUT:  if (bus.out_ready && run) pc_q <= pc_q + AW'(3);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_operand_unit.sv
// Self-checking bench: memory/register-file models with programmable wait
// states, a plain-arithmetic instruction model and directed + random tests.
module tb_inst_fetch_operand_unit;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic          run = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          busy;
  logic [AW-1:0] pc;

  inst_fetch_operand_unit_if #(.DW(DW), .AW(AW), .RW(RW)) bus ();

  inst_fetch_operand_unit #(.DW(DW), .AW(AW), .RW(RW)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .start_addr (start_addr),
    .run        (run),
    .busy       (busy),
    .pc         (pc),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] rf  [16];
  int            mem_wait = 0;
  int            wait_cnt = 0;
  logic [AW-1:0] held_addr = '0;
  int            total = 0;
  int            bad = 0;

  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= mem_wait);
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.reg_rdata = rf[bus.reg_idx];
  initial bus.out_ready = 1'b0;

  always @(posedge clk) wait_cnt <= (!bus.mem_req || bus.mem_ack) ? 0 : wait_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Address must not move between the first request cycle and the ack.
  always @(negedge clk) begin
    if (bus.mem_req && wait_cnt == 0) held_addr <= bus.mem_addr;
    if (bus.mem_req && bus.mem_ack && wait_cnt > 0)
      check("addr_stable", 32'(bus.mem_addr), 32'(held_addr));
  end

  function automatic logic [DW-1:0] resolve(input logic [1:0] mode, input logic [DW-1:0] s);
    int ea;
    logic [DW-1:0] r;
    case (mode)
      2'd0: return rf[s[3:0]];
      2'd1: return mem[s[7:0]];
      2'd2: begin
        r  = rf[s[11:8]];
        ea = (int'(s[7:0]) + int'(r[7:0])) % 256;
        return mem[ea];
      end
      default: return s;
    endcase
  endfunction

  task automatic do_start(input logic [AW-1:0] addr);
    start_addr = addr;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  // Called #1 after the edge that launches the fetch (cyc0 cycles already elapsed).
  task automatic expect_instr(input logic [AW-1:0] addr, input int stall, input int cyc0,
                              input bit start_at_hs, input string tag);
    logic [DW-1:0] w0, w1, w2, ea, eb;
    logic [AW-1:0] nxt;
    int nmem, lat, cyc;
    w0   = mem[int'(addr)];
    w1   = mem[(int'(addr) + 1) % 256];
    w2   = mem[(int'(addr) + 2) % 256];
    ea   = resolve(w0[11:10], w1);
    eb   = resolve(w0[9:8], w2);
    nmem = int'(w0[11:10] == 2'b01 || w0[11:10] == 2'b10)
         + int'(w0[9:8] == 2'b01 || w0[9:8] == 2'b10);
    lat  = 5 + nmem + mem_wait * (3 + nmem);
    cyc  = cyc0;
    while (!bus.out_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " op"}, 32'(bus.op), 32'(w0[15:12]));
    check({tag, " a"}, 32'(bus.a), 32'(ea));
    check({tag, " b"}, 32'(bus.b), 32'(eb));
    check({tag, " pc"}, 32'(pc), 32'(addr));
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      check({tag, " held valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " held op"}, 32'(bus.op), 32'(w0[15:12]));
      check({tag, " held a"}, 32'(bus.a), 32'(ea));
      check({tag, " held b"}, 32'(bus.b), 32'(eb));
    end
    bus.out_ready = 1'b1;
    if (start_at_hs) begin
      start      = 1'b1;
      start_addr = ~addr;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    start         = 1'b0;
    nxt = run ? addr + 8'd3 : addr;
    check({tag, " pc after"}, 32'(pc), 32'(nxt));
    check({tag, " busy after"}, 32'(busy), 32'(run));
  endtask

  initial begin
    int cnt;
    logic [AW-1:0] addr;
    int stall;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 16; i++)  rf[i]  = DW'($urandom);

    // Reset state, then reset asserted mid-F1 while a read is pending.
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst mem_req", 32'(bus.mem_req), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst op", 32'(bus.op), 32'd0);
    check("rst a", 32'(bus.a), 32'd0);
    check("rst b", 32'(bus.b), 32'd0);
    check("rst pc", 32'(pc), 32'd0);
    check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst reg_idx", 32'(bus.reg_idx), 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    mem_wait = 3;
    do_start(8'h10);
    cnt = 0;
    while (!(bus.mem_req && bus.mem_addr == 8'h11) && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("reach F1", 32'(cnt < 50), 32'd1);
    #2 clr = 1'b0;
    #1;
    check("midrst mem_req", 32'(bus.mem_req), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst mem_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst pc", 32'(pc), 32'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle after release", 32'(busy), 32'd0);

    // Immediate / immediate, zero-wait memory.
    mem_wait = 0;
    mem[8'h10] = 16'h3F00; mem[8'h11] = 16'h1234; mem[8'h12] = 16'hABCD;
    do_start(8'h10);
    expect_instr(8'h10, 0, 0, 1'b0, "imm");

    // Indexed on both operands, B wraps past the top of memory.
    rf[5] = 16'h0003;
    mem[8'h40] = 16'h1A00; mem[8'h41] = 16'h0520; mem[8'h42] = 16'h05FE;
    mem[8'h23] = 16'h00AA; mem[8'h01] = 16'h5A5A;
    do_start(8'h40);
    expect_instr(8'h40, 0, 0, 1'b0, "idx");

    // Memory-direct B with two wait cycles on every access.
    mem_wait = 2;
    mem[8'h50] = 16'h5D00; mem[8'h51] = 16'hC0DE; mem[8'h52] = 16'h0077;
    mem[8'h77] = 16'hBEEF;
    do_start(8'h50);
    expect_instr(8'h50, 0, 0, 1'b0, "memb");

    // start while busy is ignored.
    mem_wait = 1;
    do_start(8'h30);
    start_addr = 8'h99;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy start pc", 32'(pc), 32'h30);
    expect_instr(8'h30, 0, 1, 1'b0, "busystart");

    // Backpressure and run chaining; start at final handshake is ignored.
    mem_wait = 0;
    run = 1'b1;
    do_start(8'h80);
    expect_instr(8'h80, 4, 0, 1'b0, "run1");
    run = 1'b0;
    expect_instr(8'h83, 0, 0, 1'b1, "run2");
    repeat (3) @(posedge clk);
    #1;
    check("idle after run", 32'(busy), 32'd0);

    // pc wrap at the top of the address space.
    run = 1'b1;
    do_start(8'hFE);
    expect_instr(8'hFE, 1, 0, 1'b0, "wrap1");
    run = 1'b0;
    expect_instr(8'h01, 0, 0, 1'b0, "wrap2");

    // Random instructions, waits, stalls and run chaining.
    for (int it = 0; it < 16; it++) begin
      addr     = AW'($urandom);
      mem_wait = $urandom_range(0, 2);
      stall    = $urandom_range(0, 2);
      run      = 1'($urandom_range(0, 1));
      do_start(addr);
      expect_instr(addr, stall, 0, 1'b0, "rnd");
      if (run) begin
        run = 1'b0;
        expect_instr(addr + 8'd3, stall, 0, 1'b0, "rnd_next");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
